// File: rtl/mem_bank_pkg.sv
// Shared types, defaults and address-map helpers for the AVMM bank router.
// Helpers take a 64-bit byte address; callers cast the result to their width.
package mem_bank_pkg;

   localparam int BYTE_SHIFT       = 6;
   localparam int IL_SHIFT_DEFAULT = 12;

   typedef enum logic {
      W_IDLE  = 1'b0,
      W_BURST = 1'b1
   } t_wr_state;

   // sel_bits is log2(banks), zero for a single bank, so the mask is empty.
   function automatic logic [63:0] bank_of(
      input logic [63:0] a,
      input bit          il,
      input int          sel_bits,
      input int          byte_shift,
      input int          bank_aw,
      input int          il_shift
   );
      logic [63:0] s;
      s = il ? (a >> il_shift) : (a >> (byte_shift + bank_aw));
      return s & ((64'd1 << sel_bits) - 64'd1);
   endfunction

   // Interleaved: bank bits are squeezed out of the middle of the address.
   function automatic logic [63:0] word_of(
      input logic [63:0] a,
      input bit          il,
      input int          sel_bits,
      input int          byte_shift,
      input int          il_shift
   );
      logic [63:0] lo;
      logic [63:0] hi;
      if (!il) return a >> byte_shift;
      lo = (a >> byte_shift) & ((64'd1 << (il_shift - byte_shift)) - 64'd1);
      hi = a >> (il_shift + sel_bits);
      return (hi << (il_shift - byte_shift)) | lo;
   endfunction

endpackage

// File: rtl/avmm_mem_bank_router_rd_tracker.sv
// avmm_bank_rd_tracker: outstanding read-beat counter, current read bank,
// read stall decision, registered return path and sticky error flag.
// Ports: rd_bank/rd_burstcount/rd_acc (issue side), rd_stall (out),
// m_readdatavalid/m_readdata (banks), s_readdata/s_readdatavalid, err.
module avmm_bank_rd_tracker #(
   parameter int NUM_BANKS         = 2,
   parameter int BSEL_W            = 1,
   parameter int DATA_WIDTH        = 512,
   parameter int BURST_WIDTH       = 7,
   parameter int MAX_PENDING_READS = 64
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [BSEL_W-1:0]               rd_bank,
   input  logic [BURST_WIDTH-1:0]          rd_burstcount,
   input  logic                            rd_acc,
   output logic                            rd_stall,
   input  logic [NUM_BANKS-1:0]            m_readdatavalid,
   input  logic [NUM_BANKS*DATA_WIDTH-1:0] m_readdata,
   output logic [DATA_WIDTH-1:0]           s_readdata,
   output logic                            s_readdatavalid,
   output logic                            err_unexpected_rsp
);

   localparam int PEND_W = $clog2(MAX_PENDING_READS + 1);
   localparam int SUM_W  = ((PEND_W > BURST_WIDTH) ? PEND_W : BURST_WIDTH) + 1;

   logic [PEND_W-1:0]     rd_pending;
   logic [BSEL_W-1:0]     cur_rd_bank;
   logic [SUM_W-1:0]      want;
   logic [PEND_W-1:0]     add_v;
   logic [PEND_W-1:0]     sub_v;
   logic [NUM_BANKS-1:0]  other;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  vld_cur;
   logic                  ret;
   logic                  bad;

   assign want = SUM_W'(rd_pending) + SUM_W'(rd_burstcount);

   assign rd_stall = ((rd_pending != '0) && (rd_bank != cur_rd_bank))
                   || (want > SUM_W'(MAX_PENDING_READS));

   assign vld_cur = m_readdatavalid[cur_rd_bank];
   assign ret     = vld_cur && (rd_pending != '0);

   always_comb begin
      other = m_readdatavalid;
      other[cur_rd_bank] = 1'b0;
   end

   // A beat from the current bank with nothing pending is also unexpected.
   assign bad = (|other) || (vld_cur && (rd_pending == '0));

   always_comb begin
      sel_data = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (BSEL_W'(b) == cur_rd_bank)
            sel_data = m_readdata[b*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   assign add_v = rd_acc ? PEND_W'(rd_burstcount) : '0;
   assign sub_v = ret ? PEND_W'(1) : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_pending         <= '0;
         cur_rd_bank        <= '0;
         s_readdata         <= '0;
         s_readdatavalid    <= 1'b0;
         err_unexpected_rsp <= 1'b0;
      end else begin
         rd_pending      <= rd_pending + add_v - sub_v;
         s_readdatavalid <= ret;
         if (rd_acc) cur_rd_bank <= rd_bank;
         if (ret) s_readdata <= sel_data;
         if (bad) err_unexpected_rsp <= 1'b1;
      end
   end

endmodule

// File: rtl/avmm_mem_bank_router.sv
// N-bank AVMM memory router: address map, write-burst bank lock, command mux.
// Ports: s_* slave from DMA master, m_* flattened per-bank masters, err flag.
module avmm_mem_bank_router
   import mem_bank_pkg::*;
#(
   parameter int NUM_BANKS         = 2,
   parameter int ADDR_WIDTH        = 33,
   parameter int DATA_WIDTH        = 512,
   parameter int BANK_ADDR_WIDTH   = 26,
   parameter int BURST_WIDTH       = 7,
   parameter int MAX_PENDING_READS = 64,
   parameter int INTERLEAVE        = 0,
   parameter int IL_SHIFT          = IL_SHIFT_DEFAULT
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [ADDR_WIDTH-1:0]                s_address,
   input  logic                                 s_read,
   input  logic                                 s_write,
   input  logic [BURST_WIDTH-1:0]               s_burstcount,
   input  logic [DATA_WIDTH-1:0]                s_writedata,
   input  logic [DATA_WIDTH/8-1:0]              s_byteenable,
   output logic                                 s_waitrequest,
   output logic [DATA_WIDTH-1:0]                s_readdata,
   output logic                                 s_readdatavalid,
   output logic [NUM_BANKS*BANK_ADDR_WIDTH-1:0] m_address,
   output logic [NUM_BANKS-1:0]                 m_read,
   output logic [NUM_BANKS-1:0]                 m_write,
   output logic [NUM_BANKS*BURST_WIDTH-1:0]     m_burstcount,
   output logic [NUM_BANKS*DATA_WIDTH-1:0]      m_writedata,
   output logic [NUM_BANKS*DATA_WIDTH/8-1:0]    m_byteenable,
   input  logic [NUM_BANKS-1:0]                 m_waitrequest,
   input  logic [NUM_BANKS*DATA_WIDTH-1:0]      m_readdata,
   input  logic [NUM_BANKS-1:0]                 m_readdatavalid,
   output logic                                 err_unexpected_rsp
);

   localparam int BSEL_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
   localparam int SEL_BITS = $clog2(NUM_BANKS);
   localparam int BYTE_SH  = $clog2(DATA_WIDTH/8);
   localparam bit IL       = (INTERLEAVE != 0);

   t_wr_state                  wr_state;
   logic [BSEL_W-1:0]          addr_bank;
   logic [BSEL_W-1:0]          wr_bank;
   logic [BSEL_W-1:0]          tgt_bank;
   logic [BANK_ADDR_WIDTH-1:0] addr_word;
   logic [BANK_ADDR_WIDTH-1:0] wr_word;
   logic [BANK_ADDR_WIDTH-1:0] tgt_word;
   logic [BURST_WIDTH-1:0]     beats_left;
   logic                       rd_req;
   logic                       rd_stall;
   logic                       trk_stall;
   logic                       rd_go;
   logic                       rd_acc;
   logic                       wr_acc;
   logic                       tgt_wait;

   assign addr_bank = BSEL_W'(bank_of(64'(s_address), IL, SEL_BITS,
                                      BYTE_SH, BANK_ADDR_WIDTH, IL_SHIFT));
   assign addr_word = BANK_ADDR_WIDTH'(word_of(64'(s_address), IL,
                                               SEL_BITS, BYTE_SH, IL_SHIFT));

   // During a write burst the slave address is ignored; bank and word hold.
   assign tgt_bank = (wr_state == W_BURST) ? wr_bank : addr_bank;
   assign tgt_word = (wr_state == W_BURST) ? wr_word : addr_word;
   assign tgt_wait = m_waitrequest[tgt_bank];

   // Write wins a read/write collision; the read is simply never issued.
   assign rd_req   = s_read && !s_write;
   assign rd_stall = rd_req && ((wr_state == W_BURST) || trk_stall);
   assign rd_go    = rd_req && !rd_stall;
   assign rd_acc   = rd_go && !tgt_wait;
   assign wr_acc   = s_write && !tgt_wait;

   assign s_waitrequest = tgt_wait || rd_stall;

   always_comb begin
      m_read  = '0;
      m_write = '0;
      m_read[tgt_bank]  = rd_go;
      m_write[tgt_bank] = s_write;
   end

   assign m_address    = {NUM_BANKS{tgt_word}};
   assign m_burstcount = {NUM_BANKS{s_burstcount}};
   assign m_writedata  = {NUM_BANKS{s_writedata}};
   assign m_byteenable = {NUM_BANKS{s_byteenable}};

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_state   <= W_IDLE;
         wr_bank    <= '0;
         wr_word    <= '0;
         beats_left <= '0;
      end else begin
         unique case (wr_state)
            W_IDLE: begin
               if (wr_acc && (s_burstcount > BURST_WIDTH'(1))) begin
                  wr_state   <= W_BURST;
                  wr_bank    <= addr_bank;
                  wr_word    <= addr_word;
                  beats_left <= s_burstcount - BURST_WIDTH'(1);
               end
            end
            W_BURST: begin
               if (wr_acc) begin
                  beats_left <= beats_left - BURST_WIDTH'(1);
                  if (beats_left == BURST_WIDTH'(1)) wr_state <= W_IDLE;
               end
            end
            default: wr_state <= W_IDLE;
         endcase
      end
   end

   avmm_bank_rd_tracker #(
      .NUM_BANKS         (NUM_BANKS),
      .BSEL_W            (BSEL_W),
      .DATA_WIDTH        (DATA_WIDTH),
      .BURST_WIDTH       (BURST_WIDTH),
      .MAX_PENDING_READS (MAX_PENDING_READS)
   ) u_trk (
      .clk                (clk),
      .reset              (reset),
      .rd_bank            (addr_bank),
      .rd_burstcount      (s_burstcount),
      .rd_acc             (rd_acc),
      .rd_stall           (trk_stall),
      .m_readdatavalid    (m_readdatavalid),
      .m_readdata         (m_readdata),
      .s_readdata         (s_readdata),
      .s_readdatavalid    (s_readdatavalid),
      .err_unexpected_rsp (err_unexpected_rsp)
   );

   a_no_rd_wr: assert property (@(posedge clk) disable iff (reset)
      !(s_read && s_write));

   if (IL) begin : g_gran
      localparam int GW = 1 << (IL_SHIFT - BYTE_SH);
      logic [IL_SHIFT-BYTE_SH:0] gr_off;
      assign gr_off = {1'b0, s_address[IL_SHIFT-1:BYTE_SH]};
      // A burst starting in a granule must end in that granule.
      a_granule: assert property (@(posedge clk) disable iff (reset)
         ((wr_state == W_IDLE) && (wr_acc || rd_acc))
         |-> (32'(gr_off) + 32'(s_burstcount) <= GW));
   end

endmodule

// File: tb/tb_avmm_mem_bank_router.sv
// Directed bench for avmm_mem_bank_router: contiguous and interleaved maps,
// bank-switch stall, full tracker, error flag and reset mid-burst.
module tb_avmm_mem_bank_router;
   import mem_bank_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // contiguous instance
   logic [32:0]   s_address;
   logic          s_read, s_write;
   logic [6:0]    s_burstcount;
   logic [511:0]  s_writedata;
   logic [63:0]   s_byteenable;
   logic          s_waitrequest;
   logic [511:0]  s_readdata;
   logic          s_readdatavalid;
   logic [51:0]   m_address;
   logic [1:0]    m_read, m_write;
   logic [13:0]   m_burstcount;
   logic [1023:0] m_writedata;
   logic [127:0]  m_byteenable;
   logic [1:0]    m_waitrequest;
   logic [1023:0] m_readdata;
   logic [1:0]    m_readdatavalid;
   logic          err;

   // interleaved instance
   logic [32:0]   i_s_address;
   logic          i_s_read, i_s_write;
   logic [6:0]    i_s_burstcount;
   logic          i_s_waitrequest;
   logic [511:0]  i_s_readdata;
   logic          i_s_readdatavalid;
   logic [51:0]   i_m_address;
   logic [1:0]    i_m_read, i_m_write;
   logic [13:0]   i_m_burstcount;
   logic [1023:0] i_m_writedata;
   logic [127:0]  i_m_byteenable;
   logic [1:0]    i_m_waitrequest;
   logic [1:0]    i_m_readdatavalid;
   logic          i_err;

   avmm_mem_bank_router #(.INTERLEAVE(0)) u_dut0 (
      .clk(clk), .reset(reset),
      .s_address(s_address), .s_read(s_read), .s_write(s_write),
      .s_burstcount(s_burstcount), .s_writedata(s_writedata),
      .s_byteenable(s_byteenable), .s_waitrequest(s_waitrequest),
      .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
      .m_address(m_address), .m_read(m_read), .m_write(m_write),
      .m_burstcount(m_burstcount), .m_writedata(m_writedata),
      .m_byteenable(m_byteenable), .m_waitrequest(m_waitrequest),
      .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
      .err_unexpected_rsp(err)
   );

   avmm_mem_bank_router #(.INTERLEAVE(1)) u_dut1 (
      .clk(clk), .reset(reset),
      .s_address(i_s_address), .s_read(i_s_read), .s_write(i_s_write),
      .s_burstcount(i_s_burstcount), .s_writedata(s_writedata),
      .s_byteenable(s_byteenable), .s_waitrequest(i_s_waitrequest),
      .s_readdata(i_s_readdata), .s_readdatavalid(i_s_readdatavalid),
      .m_address(i_m_address), .m_read(i_m_read), .m_write(i_m_write),
      .m_burstcount(i_m_burstcount), .m_writedata(i_m_writedata),
      .m_byteenable(i_m_byteenable), .m_waitrequest(i_m_waitrequest),
      .m_readdata(m_readdata), .m_readdatavalid(i_m_readdatavalid),
      .err_unexpected_rsp(i_err)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [511:0] act,
                        input logic [511:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   function automatic logic [511:0] pat(input int k);
      logic [31:0] w;
      w = 32'hA5A50000 + 32'(k);
      return {16{w}};
   endfunction

   typedef struct {
      bit          il;
      logic [32:0] addr;
      bit          rd;
      logic [1:0]  exp_rd;
      logic [1:0]  exp_wr;
      logic [25:0] exp_word;
   } vec_t;

   vec_t vt[8];

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{0, 33'h0_0000_0040, 1, 2'b01, 2'b00, 26'h1};
      vt[1] = '{0, 33'h1_0000_0000, 1, 2'b10, 2'b00, 26'h0};
      vt[2] = '{0, 33'h1_0000_1FC0, 0, 2'b00, 2'b10, 26'h7F};
      vt[3] = '{0, 33'h0_FFFF_FFC0, 0, 2'b00, 2'b01, 26'h3FFFFFF};
      vt[4] = '{1, 33'h0_0000_1000, 0, 2'b00, 2'b10, 26'h0};
      vt[5] = '{1, 33'h0_0000_2040, 1, 2'b01, 2'b00, 26'h41};
      vt[6] = '{1, 33'h0_0000_3FC0, 1, 2'b10, 2'b00, 26'h7F};
      vt[7] = '{1, 33'h1_0000_0000, 0, 2'b00, 2'b01, 26'h2000000};

      reset = 1'b1;
      s_address = '0; s_read = 0; s_write = 0; s_burstcount = 7'd1;
      s_writedata = pat(55); s_byteenable = '1;
      m_waitrequest = 2'b00; m_readdata = '0; m_readdatavalid = 2'b00;
      i_s_address = '0; i_s_read = 0; i_s_write = 0; i_s_burstcount = 7'd1;
      i_m_waitrequest = 2'b00; i_m_readdatavalid = 2'b00;
      step(); step();
      reset = 1'b0;
      mid();
      check("rst_rdv", 512'(s_readdatavalid), 512'(0));
      check("rst_err", 512'(err), 512'(0));
      check("rst_mrd", 512'(m_read), 512'(0));
      check("rst_mwr", 512'(m_write), 512'(0));
      check("rst_rdata", s_readdata, 512'(0));
      check("rst_pend", 512'(u_dut0.u_trk.rd_pending), 512'(0));

      // address map table, banks busy so nothing is accepted
      m_waitrequest = 2'b11;
      i_m_waitrequest = 2'b11;
      step();
      for (int i = 0; i < 8; i++) begin
         if (vt[i].il) begin
            i_s_address = vt[i].addr;
            i_s_read = vt[i].rd; i_s_write = !vt[i].rd;
            mid();
            check($sformatf("map%0d_rd", i), 512'(i_m_read), 512'(vt[i].exp_rd));
            check($sformatf("map%0d_wr", i), 512'(i_m_write), 512'(vt[i].exp_wr));
            check($sformatf("map%0d_adr", i), 512'(i_m_address),
                  512'({2{vt[i].exp_word}}));
            check($sformatf("map%0d_wait", i), 512'(i_s_waitrequest), 512'(1));
         end else begin
            s_address = vt[i].addr;
            s_read = vt[i].rd; s_write = !vt[i].rd;
            mid();
            check($sformatf("map%0d_rd", i), 512'(m_read), 512'(vt[i].exp_rd));
            check($sformatf("map%0d_wr", i), 512'(m_write), 512'(vt[i].exp_wr));
            check($sformatf("map%0d_adr", i), 512'(m_address),
                  512'({2{vt[i].exp_word}}));
            check($sformatf("map%0d_wait", i), 512'(s_waitrequest), 512'(1));
         end
         step();
         s_read = 0; s_write = 0; i_s_read = 0; i_s_write = 0;
      end
      m_waitrequest = 2'b00;
      i_m_waitrequest = 2'b00;
      step();
      check("map_pend", 512'(u_dut0.u_trk.rd_pending), 512'(0));

      // read burst 4 from bank0, in-order return
      s_address = 33'h0_0000_0040; s_burstcount = 7'd4; s_read = 1;
      mid();
      check("rd4_mrd", 512'(m_read), 512'(2'b01));
      check("rd4_adr", 512'(m_address), 512'({2{26'h1}}));
      check("rd4_bc", 512'(m_burstcount), 512'({2{7'd4}}));
      check("rd4_wait", 512'(s_waitrequest), 512'(0));
      step();
      s_read = 0;
      for (int k = 0; k < 4; k++) begin
         m_readdatavalid = 2'b01;
         m_readdata = {pat(100 + k), pat(k)};
         step();
         check($sformatf("rd4_v%0d", k), 512'(s_readdatavalid), 512'(1));
         check($sformatf("rd4_d%0d", k), s_readdata, pat(k));
      end
      m_readdatavalid = 2'b00;
      step();
      check("rd4_vend", 512'(s_readdatavalid), 512'(0));

      // single read from bank1
      s_address = 33'h1_0000_0000; s_burstcount = 7'd1; s_read = 1;
      mid();
      check("rdb1_mrd", 512'(m_read), 512'(2'b10));
      check("rdb1_adr", 512'(m_address), 512'({2{26'h0}}));
      step();
      s_read = 0;
      m_readdatavalid = 2'b10;
      m_readdata = {pat(9), pat(200)};
      step();
      m_readdatavalid = 2'b00;
      check("rdb1_v", 512'(s_readdatavalid), 512'(1));
      check("rdb1_d", s_readdata, pat(9));
      check("rdb1_err", 512'(err), 512'(0));
      step();

      // bank switch: 16 pending on bank0 hold off a bank1 read
      s_address = 33'h0; s_burstcount = 7'd16; s_read = 1;
      step();
      s_address = 33'h1_0000_0000; s_burstcount = 7'd1;
      for (int k = 0; k < 16; k++) begin
         m_readdatavalid = 2'b01;
         m_readdata = {pat(0), pat(300 + k)};
         mid();
         check($sformatf("bsw_wait%0d", k), 512'(s_waitrequest), 512'(1));
         if (k == 0) check("bsw_mrd0", 512'(m_read), 512'(0));
         step();
      end
      m_readdatavalid = 2'b00;
      mid();
      check("bsw_go_wait", 512'(s_waitrequest), 512'(0));
      check("bsw_go_mrd", 512'(m_read), 512'(2'b10));
      step();
      s_read = 0;
      m_readdatavalid = 2'b10;
      m_readdata = {pat(77), pat(0)};
      step();
      m_readdatavalid = 2'b00;
      check("bsw_b1_v", 512'(s_readdatavalid), 512'(1));
      check("bsw_b1_d", s_readdata, pat(77));
      step();
      check("bsw_pend", 512'(u_dut0.u_trk.rd_pending), 512'(0));

      // full tracker: 64 outstanding block a further beat
      s_address = 33'h0; s_burstcount = 7'd64; s_read = 1;
      step();
      s_burstcount = 7'd1;
      mid();
      check("full_wait", 512'(s_waitrequest), 512'(1));
      check("full_mrd", 512'(m_read), 512'(0));
      check("full_pend", 512'(u_dut0.u_trk.rd_pending), 512'(64));
      step();
      m_readdatavalid = 2'b01;
      mid();
      check("full_wait2", 512'(s_waitrequest), 512'(1));
      step();
      m_readdatavalid = 2'b00;
      mid();
      check("full_rel_wait", 512'(s_waitrequest), 512'(0));
      check("full_rel_mrd", 512'(m_read), 512'(2'b01));
      check("full_rel_pend", 512'(u_dut0.u_trk.rd_pending), 512'(63));
      step();
      s_read = 0;
      mid();
      check("full_pend64", 512'(u_dut0.u_trk.rd_pending), 512'(64));
      for (int k = 0; k < 64; k++) begin
         m_readdatavalid = 2'b01;
         step();
      end
      m_readdatavalid = 2'b00;
      step();
      check("full_drain", 512'(u_dut0.u_trk.rd_pending), 512'(0));
      check("full_err", 512'(err), 512'(0));

      // current-bank beat with nothing pending
      m_readdatavalid = 2'b01;
      step();
      m_readdatavalid = 2'b00;
      check("err0_flag", 512'(err), 512'(1));
      check("err0_rdv", 512'(s_readdatavalid), 512'(0));

      // reset in the middle of a write burst
      s_address = 33'h1_0000_0000; s_burstcount = 7'd4; s_write = 1;
      mid();
      check("wrr_mwr0", 512'(m_write), 512'(2'b10));
      step();
      s_address = 33'h0;
      mid();
      check("wrr_mwr1", 512'(m_write), 512'(2'b10));
      check("wrr_st", 512'(u_dut0.wr_state), 512'(W_BURST));
      step();
      reset = 1'b1;
      s_write = 0;
      step();
      reset = 1'b0;
      mid();
      check("wrr_st_idle", 512'(u_dut0.wr_state), 512'(W_IDLE));
      check("wrr_err", 512'(err), 512'(0));
      check("wrr_mwr", 512'(m_write), 512'(0));
      check("wrr_rdv", 512'(s_readdatavalid), 512'(0));
      step();
      s_burstcount = 7'd1; s_write = 1;
      mid();
      check("wrr_new_mwr", 512'(m_write), 512'(2'b01));
      step();
      s_write = 0;

      // other bank beat while idle
      m_readdatavalid = 2'b10;
      step();
      m_readdatavalid = 2'b00;
      check("err1_flag", 512'(err), 512'(1));
      check("err1_rdv", 512'(s_readdatavalid), 512'(0));
      step();
      check("err1_sticky", 512'(err), 512'(1));

      // interleaved write burst 8 locked to bank1 word 0
      i_m_waitrequest = 2'b01;
      i_s_burstcount = 7'd8; i_s_write = 1;
      for (int k = 0; k < 8; k++) begin
         i_s_address = (k == 0) ? 33'h1000 : 33'(k * 64);
         if (k == 3) begin
            i_m_waitrequest = 2'b11;
            mid();
            check("il_stall", 512'(i_s_waitrequest), 512'(1));
            step();
            i_m_waitrequest = 2'b01;
         end
         mid();
         check($sformatf("il_mwr%0d", k), 512'(i_m_write), 512'(2'b10));
         check($sformatf("il_adr%0d", k), 512'(i_m_address), 512'({2{26'h0}}));
         check($sformatf("il_wait%0d", k), 512'(i_s_waitrequest), 512'(0));
         step();
      end
      i_s_write = 0;
      mid();
      check("il_end_mwr", 512'(i_m_write), 512'(0));
      check("il_end_st", 512'(u_dut1.wr_state), 512'(W_IDLE));
      check("il_err", 512'(i_err), 512'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
